// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared configuration constants and state type for the console
//             UART receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Bit period in clocks is c_clks_per_bit + 1
    localparam int c_clks_per_bit      = 216;
    // Receive FIFO entries when the FIFO build option is enabled
    localparam int c_uart_rx_fifo_depth = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Brief    : Valid/ready byte handshake from the receiver to its consumer,
//             plus the one-cycle error pulses.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    // Receiver side
    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ready
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Small synchronous FIFO (pointers + occupancy count) buffering
//             received bytes. A push into a full FIFO is accepted only when a
//             pop frees a slot in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [WIDTH-1:0] head_o
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (count_q == c_cnt_w'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // Pointer and occupancy registers; power-of-2 depth wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 serial receiver. Synchronises the rx pin, frames bytes by
//             mid-bit sampling and hands them out over a valid/ready port.
//             Build option UART_RX_FIFO_EN replaces the single holding
//             register with a FIFO_DEPTH-entry receive FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_clks_per_bit
`ifdef UART_RX_FIFO_EN
  , parameter int FIFO_DEPTH   = c_uart_rx_fifo_depth
`endif
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  uart_rx_i,
    uart_rx_if.master  rx
);
    localparam int                  c_cnt_w = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_cnt_w-1:0]  c_half  = c_cnt_w'(CLKS_PER_BIT / 2);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(CLKS_PER_BIT);

    logic               sync1_q;
    logic               sync2_q;
    uart_rx_state_t     state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         shift_q;
    logic               frame_err_q;
    logic               overrun_q;

    logic               w_line;
    logic               w_cnt_done;
    logic               w_push;

    assign w_line     = sync2_q;
    assign w_cnt_done = (cnt_q == c_last);
    // A good stop bit completes a byte this cycle
    assign w_push     = (state_q == STOP) && w_cnt_done && w_line;

    // Two-flop synchroniser on the asynchronous line, idle-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Framing FSM: half-bit start qualification, then one sample per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!w_line) state_q <= START;
                end
                START: begin
                    if (cnt_q == c_half) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        // A start bit gone high by mid-bit is a glitch
                        state_q <= w_line ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                DATA: begin
                    if (w_cnt_done) begin
                        shift_q[idx_q] <= w_line;
                        cnt_q          <= '0;
                        if (idx_q == 3'd7) state_q <= STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                STOP: begin
                    if (w_cnt_done) begin
                        cnt_q       <= '0;
                        frame_err_q <= !w_line;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic [7:0] w_head;

    assign w_pop = !w_empty && rx.rx_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (shift_q),
        .pop_i       (w_pop),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

    // Overrun only when full and no slot is freed this cycle
    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= w_push && w_full && !w_pop;
    end

    assign rx.rx_valid = !w_empty;
    assign rx.rx_data  = w_empty ? 8'h00 : w_head;
`else
    logic [7:0] data_q;
    logic       valid_q;
    logic       w_accept;

    assign w_accept = valid_q && rx.rx_ready;

    // Single holding register; an accept in the delivery cycle frees it
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (w_push) begin
                if (!valid_q || w_accept) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (w_accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_valid = valid_q;
    assign rx.rx_data  = data_q;
`endif

    assign rx.rx_frame_err = frame_err_q;
    assign rx.rx_overrun   = overrun_q;
endmodule
`default_nettype wire
